// File: rtl/adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibble counter width; never narrower than one bit so WIDTH=4 still has a counter.
  function automatic int cnt_w(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple adder; exposes the carry into bit 3 for signed overflow.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign c3   = c[3];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice reused NIBBLES times,
// carry held in a register between nibbles, valid/ready on both sides.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = cnt_w(NIBBLES);

  state_t state, state_nxt;

  logic [WIDTH-1:0]          a_reg, b_reg, sum_reg;
  logic [WIDTH+NIBBLE_W-1:0] sum_cat;
  logic [CW-1:0]             cnt;
  logic                      carry, cout_reg, ovf_reg;
  logic [NIBBLE_W-1:0]       slice_s;
  logic                      slice_c3, slice_co;
  logic                      last;

  assign last    = (cnt == CW'(NIBBLES - 1));
  // New nibble enters at the top; concatenate-then-slice keeps WIDTH=4 legal.
  assign sum_cat = {slice_s, sum_reg};

  nibble_add4 u_slice (
    .a    (a_reg[NIBBLE_W-1:0]),
    .b    (b_reg[NIBBLE_W-1:0]),
    .cin  (carry),
    .s    (slice_s),
    .c3   (slice_c3),
    .cout (slice_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: accept in IDLE, step nibbles in RUN, hold result in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, nibble shifting, carry chain and result latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_reg    <= a;
          b_reg    <= b;
          carry    <= cin;
          sum_reg  <= '0;
          cnt      <= '0;
          cout_reg <= 1'b0;
          ovf_reg  <= 1'b0;
        end
        ST_RUN: begin
          a_reg   <= a_reg >> NIBBLE_W;
          b_reg   <= b_reg >> NIBBLE_W;
          sum_reg <= sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
          carry   <= slice_co;
          cnt     <= cnt + CW'(1);
          if (last) begin
            cout_reg <= slice_co;
            ovf_reg  <= slice_c3 ^ slice_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, cout, overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one operation, check latency and busy flags, then drain with out_ready.
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic [W-1:0] es, input logic eco, input logic eov,
                       input string nm);
    int  n;
    logic busy_ok;
    @(negedge clk);
    chk({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~va; b = vb ^ 16'h5A5A; cin = ~vc;
    n = 0;
    busy_ok = 1'b1;
    while (!out_valid && n < 20) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready) busy_ok = 1'b0;
    chk({nm, " latency"}, 32'(n), 32'd4);
    chk({nm, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({nm, " sum"}, {16'd0, sum}, {16'd0, es});
    chk({nm, " cout"}, {31'd0, cout}, {31'd0, eco});
    chk({nm, " ovf"}, {31'd0, overflow}, {31'd0, eov});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (out_valid || !in_ready) chk({nm, " drain"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W:0]   ref17;
    logic [W-1:0] ra, rb;
    logic         rc, rov;

    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5]  = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[6]  = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{16'h89AB, 16'h7654, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[10] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst sum", {16'd0, sum}, 32'd0);
    chk("rst cout/ovf", {30'd0, cout, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov,
            $sformatf("vec%0d", i));

    // Backpressure: result must hold while inputs churn and out_ready is low.
    begin
      int n;
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp valid", {31'd0, out_valid}, 32'd1);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        a = 16'(k * 16'h1111); b = ~a; in_valid = k[0];
        @(posedge clk);
        #1;
        if (sum !== 16'h5555 || cout || overflow || !out_valid || in_ready)
          chk($sformatf("bp hold%0d", k), {sum, 12'd0, cout, overflow, out_valid, in_ready},
              {16'h5555, 16'h0002});
        else checks++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp release", {30'd0, out_valid, in_ready}, 32'd1);
    end

    // Asynchronous reset two cycles into RUN discards the partial sum.
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre-rst partial", {16'd0, sum}, 32'hDE00);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst sum", {16'd0, sum}, 32'd0);
    chk("async rst flags", {29'd0, out_valid, in_ready, cout}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, "post-rst");

    // Random operations against an arithmetic reference.
    for (int r = 0; r < 20; r++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      ref17 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      rov = (ra[15] == rb[15]) && (ref17[15] != ra[15]);
      do_op(ra, rb, rc, ref17[15:0], ref17[16], rov, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder. It processes 4 bits per clock through a single 4-bit ripple slice, with the carry held in a register between cycles.
- It is the additive counterpart of the team's 4-bit ripple subtractor.
- It sits in the rank-accumulation datapath, summing rank contributions with small area.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- WIDTH, 16: operand/sum width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4: derived, not overridable; number of RUN cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and cin valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  addend A, unsigned or two's complement.
- b  in  WIDTH  addend B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  sum/cout/overflow valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  a+b+cin mod 2^WIDTH.
- cout  out  1  carry out of MSB.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock domain (clk). rst is asynchronous, active-high. These are fixed.
- States: IDLE, RUN, DONE.
- On rst: state=IDLE, nibble counter=0, carry reg=0, operand regs=0. Outputs: sum=0, cout=0, overflow=0, out_valid=0.
- in_ready = (state==IDLE), decoded combinationally from state; it is therefore 1 while rst is held.
- IDLE: on an edge with in_valid&in_ready:
  - capture a, b; carry reg<=cin; sum reg<=0; counter<=0; go to RUN.
  - in_valid without in_ready has no effect.
- RUN, each cycle:
  - the slice adds a_reg[3:0] + b_reg[3:0] + carry reg.
  - a_reg and b_reg shift right 4; the nibble result shifts into sum_reg[WIDTH-1:WIDTH-4] (sum reg shifts right 4).
  - carry reg <= slice carry-out; counter increments.
  - On the edge processing nibble NIBBLES-1: latch overflow = (carry into bit 3 of slice) XOR (slice cout); cout<=slice cout; go to DONE.
- Latency: out_valid rises NIBBLES edges after the accepting edge (4 for WIDTH=16).
- DONE:
  - out_valid=1; sum, cout, overflow held stable until out_valid&out_ready.
  - On the handshake: out_valid<=0, go to IDLE.
  - in_ready stays 0 in RUN and DONE; no overlap of operations. Throughput is one result per NIBBLES+2 cycles minimum.
- Inputs a, b, cin are ignored outside the accepting edge; changing them mid-operation must not affect the result.
- out_ready is ignored outside DONE.
- Reset asserted mid-RUN or mid-DONE aborts immediately to reset values; the partial result is discarded.
- WIDTH=4: a single RUN cycle; behaviour is otherwise identical.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the unsigned carry; overflow is valid for two's complement interpretation only.

Decomposition:
- Shared package (adder_pkg):
  - NIBBLE_W=4.
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Counter width function clog2(NIBBLES), minimum 1.
- Sub-module nibble_add4: combinational 4-bit ripple adder built from the existing fa cell.
  - Ports: a[3:0], b[3:0], cin, s[3:0], c3 (carry into bit 3), cout.
  - Instantiated once.
  - Top level holds the FSM, shift registers and counter.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, overflow=0; out_valid rises exactly 4 edges after the accept edge; in_ready=0 during RUN/DONE.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Separately, a=0x0000, b=0xFFFF, cin=1 → sum=0x0000, cout=1, overflow=0.
- a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1. Separately, a=0x8000, b=0x8000 → sum=0x0000, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, while toggling a/b/in_valid → sum/cout/overflow constant, no second accept. Then out_ready=1 for one cycle → out_valid=0 and in_ready=1 next cycle.
- Reset: assert rst asynchronously 2 cycles into RUN (a=0xABCD, b=0x1111) → outputs 0 immediately, state IDLE. After release, 0x0F0F+0xF0F0 gives sum=0xFFFF, cout=0.
- Randomized back-to-back ops with out_ready=1 compared against a+b+cin reference model; minimum spacing between accepts is 6 cycles for WIDTH=16.
